// File: rtl/id_fetch_ctrl_if.sv
// Fetch/decode boundary bundle: fetch payload in, fetch control out, plus the
// hazard sideband and the ID/EX payload handed to the next stage.
interface id_fetch_ctrl_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus_4;
  logic [31:0]     if_instruction;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic [4:0]      ex_rd;
  logic            mem_mem_read;
  logic [4:0]      mem_rd;

  logic            stall_f;
  logic            pc_src;
  logic [XLEN-1:0] pc_branch_dest;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc_plus_4;
  logic [31:0]     id_instruction;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;

  // Pipeline side: supplies fetch payload and hazard info, consumes control.
  modport master (
    output if_pc, if_pc_plus_4, if_instruction, rs1_data, rs2_data,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
    input  stall_f, pc_src, pc_branch_dest, id_valid, id_pc, id_pc_plus_4,
           id_instruction, rs1_addr, rs2_addr
  );

  // Controller side.
  modport slave (
    input  if_pc, if_pc_plus_4, if_instruction, rs1_data, rs2_data,
           ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
    output stall_f, pc_src, pc_branch_dest, id_valid, id_pc, id_pc_plus_4,
           id_instruction, rs1_addr, rs2_addr
  );
endinterface

// File: rtl/id_fetch_ctrl.sv
// IF/ID pipeline register with ID-stage branch resolution, hazard stalls and
// wrong-path squashing after a redirect.
module id_fetch_ctrl #(
  parameter int XLEN         = 32,
  parameter int SQUASH_SLOTS = 2
) (
  input  logic          clk,
  input  logic          reset,
  id_fetch_ctrl_if.slave bus
);

  localparam int CW = (SQUASH_SLOTS > 0) ? $clog2(SQUASH_SLOTS + 1) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {RUN, SQUASH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q;
  logic [XLEN-1:0] pc_q, pc4_q;
  logic [31:0]     instr_q;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2;
  logic            is_branch, is_jal, is_jalr, uses_rs1, uses_rs2;
  logic [XLEN-1:0] b_imm, j_imm, i_imm;
  logic            load_use, branch_haz, stall, taken, redirect;
  logic [XLEN-1:0] dest;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_jalr   = (opcode == OP_JALR);
  assign uses_rs1  = (opcode == OP_REG) || (opcode == OP_IMM) || (opcode == OP_LOAD) ||
                     (opcode == OP_STORE) || is_branch || is_jalr;
  assign uses_rs2  = (opcode == OP_REG) || (opcode == OP_STORE) || is_branch;

  assign b_imm = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0}));
  assign j_imm = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0}));
  assign i_imm = XLEN'($signed(instr_q[31:20]));

  function automatic logic src_match(input logic [4:0] rd, input logic [4:0] a1,
                                     input logic [4:0] a2, input logic u1, input logic u2);
    return (u1 && (rd == a1)) || (u2 && (rd == a2));
  endfunction

  assign load_use = valid_q && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    src_match(bus.ex_rd, rs1, rs2, uses_rs1, uses_rs2);

  // Branch/JALR compare in ID, so even a plain ALU result still in EX is too late.
  assign branch_haz = valid_q && (is_branch || is_jalr) &&
                      ((bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
                        src_match(bus.ex_rd, rs1, rs2, uses_rs1, uses_rs2)) ||
                       (bus.mem_mem_read && (bus.mem_rd != 5'd0) &&
                        src_match(bus.mem_rd, rs1, rs2, uses_rs1, uses_rs2)));

  assign stall = load_use || branch_haz;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    taken = 1'b0;
    if (is_jal || is_jalr) begin
      taken = 1'b1;
    end else if (is_branch) begin
      case (funct3)
        3'b000:  taken = (bus.rs1_data == bus.rs2_data);
        3'b001:  taken = (bus.rs1_data != bus.rs2_data);
        3'b100:  taken = ($signed(bus.rs1_data) <  $signed(bus.rs2_data));
        3'b101:  taken = ($signed(bus.rs1_data) >= $signed(bus.rs2_data));
        3'b110:  taken = (bus.rs1_data <  bus.rs2_data);
        3'b111:  taken = (bus.rs1_data >= bus.rs2_data);
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    dest = '0;
    if (is_branch)    dest = pc_q + b_imm;
    else if (is_jal)  dest = pc_q + j_imm;
    else if (is_jalr) dest = (bus.rs1_data + i_imm) & ~XLEN'(1);
  end

  assign redirect = valid_q && !stall && taken;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      if (redirect) begin
        cnt_d   = CW'(SQUASH_SLOTS);
        state_d = (SQUASH_SLOTS > 0) ? SQUASH : RUN;
      end else if (state_q == SQUASH) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = RUN;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      pc4_q   <= '0;
      instr_q <= NOP;
    end else if (!stall) begin
      valid_q <= (cnt_q == '0) && !redirect;
      pc_q    <= bus.if_pc;
      pc4_q   <= bus.if_pc_plus_4;
      instr_q <= bus.if_instruction;
    end
  end

  assign bus.stall_f        = stall;
  assign bus.pc_src         = redirect;
  assign bus.pc_branch_dest = dest;
  assign bus.id_valid       = valid_q;
  assign bus.id_pc          = pc_q;
  assign bus.id_pc_plus_4   = pc4_q;
  assign bus.id_instruction = instr_q;
  assign bus.rs1_addr       = rs1;
  assign bus.rs2_addr       = rs2;

endmodule

// File: doc/id_fetch_ctrl.md
Name: id_fetch_ctrl

Overview:
- Decode-side counterpart of the fetch stage. Registers the fetch outputs (pc, pc_plus_4, instruction) into the IF/ID pipeline register.
- Resolves branches and jumps in ID, then drives the fetch control inputs: pc_src, pc_branch_dest and stall_f.
- Detects load-use and branch-operand hazards, and squashes wrong-path fetches after a redirect.
- Sits between the fetch stage and the ID/EX register.

Parameters:
- XLEN, 32, datapath and PC width.
- SQUASH_SLOTS, 2, number of fetched instructions invalidated after a redirect. Covers the fetch stage's registered next-PC plus the in-flight fetch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- if_pc  in  XLEN  PC from fetch.
- if_pc_plus_4  in  XLEN  PC+4 from fetch.
- if_instruction  in  32  instruction from fetch.
- rs1_data  in  XLEN  forwarded rs1 value for the ID instruction.
- rs2_data  in  XLEN  forwarded rs2 value for the ID instruction.
- ex_reg_write  in  1  EX-stage instruction writes rd.
- ex_mem_read  in  1  EX-stage instruction is a load.
- ex_rd  in  5  EX-stage destination register.
- mem_mem_read  in  1  MEM-stage instruction is a load.
- mem_rd  in  5  MEM-stage destination register.
- stall_f  out  1  hold fetch and IF/ID.
- pc_src  out  1  redirect fetch to pc_branch_dest.
- pc_branch_dest  out  XLEN  redirect target.
- id_valid  out  1  ID/EX payload is a real instruction.
- id_pc  out  XLEN  PC of the ID instruction.
- id_pc_plus_4  out  XLEN  PC+4 of the ID instruction.
- id_instruction  out  32  instruction in ID.
- rs1_addr  out  5  instruction[19:15] of the ID instruction.
- rs2_addr  out  5  instruction[24:20] of the ID instruction.

Behaviour:
- Reset (reset low):
  - IF/ID register cleared: valid=0, pc=0, pc_plus_4=0, instruction=32'h00000013 (NOP).
  - Squash counter = 0, FSM = RUN.
  - All combinational outputs evaluate to 0 (stall_f, pc_src, pc_branch_dest).
  - Applies asynchronously, including mid-squash and mid-stall.
- IF/ID register:
  - stall_f=1: hold all fields and the squash counter.
  - Otherwise capture the if_* inputs. Captured valid = (squash_cnt==0) && !pc_src.
  - id_* outputs come directly from the register; id_valid is the register's valid bit.
- Instruction classes (on the registered instruction):
  - BRANCH: opcode 7'b1100011.
  - JAL: opcode 7'b1101111.
  - JALR: opcode 7'b1100111.
  - uses_rs1 for R/I/S/B/JALR; uses_rs2 for R/S/B.
- Load-use hazard: id_valid && ex_mem_read && ex_rd!=0 && ((uses_rs1 && ex_rd==rs1_addr) || (uses_rs2 && ex_rd==rs2_addr)).
- Branch-operand hazard: id_valid && (BRANCH||JALR) && a used source matches either:
  - ex_rd with ex_reg_write && ex_rd!=0, or
  - mem_rd with mem_mem_read && mem_rd!=0.
- stall_f = load-use hazard || branch-operand hazard. Combinational; no registered delay.
- Taken decision: pc_src = id_valid && !stall_f && taken.
  - pc_src is never asserted while stall_f=1.
  - JAL and JALR are always taken.
  - BRANCH uses funct3: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge. Funct3 010/011 are not taken.
- Target (pc_branch_dest):
  - BRANCH: id_pc + sext(B-imm).
  - JAL: id_pc + sext(J-imm).
  - JALR: (rs1_data + sext(I-imm)) & ~1.
  - Arithmetic is modulo 2^XLEN (wrap-around, no trap). Output is 0 when not a control-flow instruction.
- Squash FSM:
  - RUN: squash_cnt==0.
  - SQUASH: squash_cnt>0.
  - On an edge with pc_src=1, load squash_cnt=SQUASH_SLOTS and go to SQUASH.
  - In SQUASH, on each non-stalled edge, capture with valid=0 and decrement; return to RUN when the count reaches 0.
  - A stall in SQUASH holds the count.
  - A redirect cannot occur in SQUASH, because the ID instruction is invalid there.
- Invalid (bubble) ID instructions never stall or redirect.

Test Plan:
- Reset release, fetch supplies sequential ADDI at pc 0,4,8 -> id_valid=1 from the first capture; id_pc tracks 0,4,8; stall_f=0; pc_src=0.
- BEQ x1,x2,+16 at pc 8 with rs1_data=rs2_data=5 -> pc_src=1 and pc_branch_dest=24 for one cycle; the next 2 captures have id_valid=0; the instruction from pc 24 arrives with id_valid=1.
- LW x5 in EX (ex_mem_read=1, ex_rd=5), ADD x6,x5,x1 in ID -> stall_f=1 for exactly one cycle with id_* held; ex_rd=0 variant -> no stall.
- JALR x0,0(x3) with rs1_data=0x103 -> pc_branch_dest=0x102; BLTU with rs1=0xFFFFFFFF, rs2=1 not taken, while BLT is taken.
- BNE whose rs1 matches a MEM load (mem_mem_read=1) -> stall_f=1 with pc_src=0 during the stall; the redirect issues after the stall clears.
- Assert reset mid-squash (squash_cnt=1) -> outputs clear immediately; after release the FSM is in RUN and the first capture is valid.
